// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode and control-field encodings for the multi-cycle MIPS controller
package mips_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, R_WB, ADDI_EX, ADDI_WB, BRANCH, JUMP,
        MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ILLEGAL
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_INC   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIFT = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_RTYPE:      return EXEC_R;
            OP_ADDI:       return ADDI_EX;
            OP_BEQ, OP_BNE: return BRANCH;
            OP_J:          return JUMP;
            OP_LW, OP_SW:  return MEM_ADDR;
            default:       return ILLEGAL;
        endcase
    endfunction
endpackage

// File: rtl/mips_ctrl_param_if.sv
// mips_ctrl_param_if: controller <-> datapath/memory signal bundle
interface mips_ctrl_param_if #(parameter int BEATS = 4);
    logic [5:0]       opcode_i;
    logic             mem_ready_i;
    logic [BEATS-1:0] ir_write;
    logic             pc_write;
    logic             branch;
    logic             branch_ne;
    logic [1:0]       pc_src;
    logic             iord;
    logic             mem_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             fetch_en;
    logic             illegal;
    modport master (
        input  opcode_i, mem_ready_i,
        output ir_write, pc_write, branch, branch_ne, pc_src, iord, mem_write,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
               fetch_en, illegal
    );
    modport slave (
        output opcode_i, mem_ready_i,
        input  ir_write, pc_write, branch, branch_ne, pc_src, iord, mem_write,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
               fetch_en, illegal
    );
endinterface

// File: rtl/ctrl_beat_cnt.sv
// ctrl_beat_cnt: instruction-fetch beat counter, wraps after BEATS-1
module ctrl_beat_cnt #(
    parameter int BEATS = 4,
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);
    assign last = count == CW'(BEATS - 1);
    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else if (inc) count <= last ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/mips_ctrl_param.sv
// mips_ctrl_param: multi-cycle MIPS control FSM with a MEM_W-wide, BEATS-beat instruction fetch
module mips_ctrl_param
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_W = 8,
    parameter int BEATS = 32 / MEM_W
) (
    input  logic clk_i_top,
    input  logic rst_i_top,
    mips_ctrl_param_if.master bus
);
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    state_t state, state_n, st;
    logic rst_q, rdy, last;
    logic [CW-1:0] beat;
    // the reset cycle and the one after it behave as a stalled FETCH beat 0
    assign rdy = bus.mem_ready_i & ~rst_i_top & ~rst_q;
    assign st  = rst_i_top ? FETCH : state;
    ctrl_beat_cnt #(.BEATS(BEATS)) u_beat (
        .clk(clk_i_top), .rst(rst_i_top), .clr(state != FETCH),
        .inc(state == FETCH && rdy), .count(beat), .last(last)
    );
    always_ff @(posedge clk_i_top) begin
        state <= rst_i_top ? FETCH : state_n;
        rst_q <= rst_i_top;
    end
    always_comb begin
        state_n = state;
        case (state)
            FETCH:    state_n = (rdy && last) ? DECODE : FETCH;
            DECODE:   state_n = decode_next(bus.opcode_i);
            EXEC_R:   state_n = R_WB;
            ADDI_EX:  state_n = ADDI_WB;
            MEM_ADDR: state_n = bus.opcode_i == OP_SW ? MEM_WR : MEM_RD;
            MEM_RD:   state_n = rdy ? MEM_WB : MEM_RD;
            MEM_WR:   state_n = rdy ? FETCH : MEM_WR;
            default:  state_n = FETCH;
        endcase
    end
    always_comb begin
        bus.ir_write   = '0;
        bus.pc_write   = 1'b0;
        bus.branch     = 1'b0;
        bus.branch_ne  = 1'b0;
        bus.pc_src     = PC_ALU;
        bus.iord       = 1'b0;
        bus.mem_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_B;
        bus.alu_op     = ALU_ADD;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.fetch_en   = 1'b0;
        bus.illegal    = 1'b0;
        case (st)
            FETCH: begin
                bus.alu_src_b = SRCB_INC;
                bus.ir_write  = rdy ? BEATS'(1) << beat : '0;
                bus.pc_write  = rdy;
            end
            DECODE: begin
                bus.alu_src_b = SRCB_SHIFT;
                bus.fetch_en  = 1'b1;
            end
            EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
            end
            ADDI_EX, MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            ADDI_WB: bus.reg_write = 1'b1;
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_SUB;
                bus.pc_src    = PC_ALUOUT;
                bus.branch    = bus.opcode_i == OP_BEQ;
                bus.branch_ne = bus.opcode_i == OP_BNE;
            end
            JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = PC_JUMP;
            end
            MEM_RD: bus.iord = 1'b1;
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            ILLEGAL: bus.illegal = 1'b1;
            default: bus.illegal = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_mips_ctrl_param.sv
// tb_mips_ctrl_param: table-driven cycle-by-cycle check of the controller at MEM_W=8, plus 32/16-bit corner sequences
module tb_mips_ctrl_param;
    typedef struct packed {
        logic [3:0] irw;
        logic       pcw, br, bne;
        logic [1:0] pcs;
        logic       iord, mw, sa;
        logic [1:0] sb, op;
        logic       rw, rd, m2r, fe, ill;
    } outs_t;
    typedef enum {F, D, XR, RWB, AX, AWB, BQ, BN, JP, MA, MR, MWB, MW, IL} s_e;
    typedef struct {
        logic       rst;
        logic [5:0] opc;
        logic       rdy;
        outs_t      exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;
    vec_t vec[$];
    always #5 clk = ~clk;
    mips_ctrl_param_if #(.BEATS(4)) if8 ();
    mips_ctrl_param_if #(.BEATS(1)) if32 ();
    mips_ctrl_param_if #(.BEATS(2)) if16 ();
    mips_ctrl_param #(.MEM_W(8))  u8  (.clk_i_top(clk), .rst_i_top(rst), .bus(if8));
    mips_ctrl_param #(.MEM_W(32)) u32 (.clk_i_top(clk), .rst_i_top(rst), .bus(if32));
    mips_ctrl_param #(.MEM_W(16)) u16 (.clk_i_top(clk), .rst_i_top(rst), .bus(if16));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask
    function automatic outs_t exp_of(input s_e s, input int k, input bit wr);
        outs_t o = '0;
        case (s)
            F: begin
                o.sb = 2'b01;
                if (wr) begin
                    o.irw = 4'(1 << k);
                    o.pcw = 1'b1;
                end
            end
            D:   begin o.sb = 2'b11; o.fe = 1'b1; end
            XR:  begin o.sa = 1'b1; o.op = 2'b10; end
            RWB: begin o.rw = 1'b1; o.rd = 1'b1; end
            AX, MA: begin o.sa = 1'b1; o.sb = 2'b10; end
            AWB: o.rw = 1'b1;
            BQ:  begin o.sa = 1'b1; o.op = 2'b01; o.pcs = 2'b01; o.br = 1'b1; end
            BN:  begin o.sa = 1'b1; o.op = 2'b01; o.pcs = 2'b01; o.bne = 1'b1; end
            JP:  begin o.pcw = 1'b1; o.pcs = 2'b10; end
            MR:  o.iord = 1'b1;
            MWB: begin o.rw = 1'b1; o.m2r = 1'b1; end
            MW:  begin o.iord = 1'b1; o.mw = 1'b1; end
            IL:  o.ill = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction
    function automatic outs_t act8();
        return outs_t'({if8.ir_write, if8.pc_write, if8.branch, if8.branch_ne, if8.pc_src,
                        if8.iord, if8.mem_write, if8.alu_src_a, if8.alu_src_b, if8.alu_op,
                        if8.reg_write, if8.reg_dst, if8.mem_to_reg, if8.fetch_en, if8.illegal});
    endfunction
    task automatic add(input bit r, input logic [5:0] opc, input bit rdy, input s_e s, input int k, input bit wr);
        vec.push_back('{r, opc, rdy, exp_of(s, k, wr)});
    endtask
    task automatic fetch4(input logic [5:0] opc);
        for (int k = 0; k < 4; k++) add(0, opc, 1, F, k, 1);
        add(0, opc, 1, D, 0, 0);
    endtask
    initial begin
        {if8.opcode_i, if32.opcode_i, if16.opcode_i} = '0;
        {if8.mem_ready_i, if32.mem_ready_i, if16.mem_ready_i} = '0;
        add(1, 6'h00, 1, F, 0, 0);
        add(0, 6'h00, 1, F, 0, 0);
        fetch4(6'h00); add(0, 6'h00, 1, XR, 0, 0); add(0, 6'h00, 1, RWB, 0, 0);
        fetch4(6'h08); add(0, 6'h08, 1, AX, 0, 0); add(0, 6'h08, 1, AWB, 0, 0);
        fetch4(6'h04); add(0, 6'h04, 1, BQ, 0, 0);
        fetch4(6'h05); add(0, 6'h05, 1, BN, 0, 0);
        fetch4(6'h02); add(0, 6'h02, 1, JP, 0, 0);
        fetch4(6'h2b); add(0, 6'h2b, 1, MA, 0, 0); add(0, 6'h2b, 1, MW, 0, 0);
        fetch4(6'h23); add(0, 6'h23, 1, MA, 0, 0); add(0, 6'h23, 1, MR, 0, 0); add(0, 6'h23, 1, MWB, 0, 0);
        add(0, 6'h23, 1, F, 0, 1);
        add(0, 6'h23, 0, F, 1, 0);
        add(0, 6'h23, 0, F, 1, 0);
        add(0, 6'h23, 1, F, 1, 1);
        add(0, 6'h23, 1, F, 2, 1);
        add(0, 6'h23, 1, F, 3, 1);
        add(0, 6'h23, 1, D, 0, 0); add(0, 6'h23, 1, MA, 0, 0);
        add(0, 6'h23, 0, MR, 0, 0); add(0, 6'h23, 1, MR, 0, 0); add(0, 6'h23, 1, MWB, 0, 0);
        fetch4(6'h3f); add(0, 6'h3f, 1, IL, 0, 0);
        fetch4(6'h00); add(0, 6'h00, 1, XR, 0, 0); add(0, 6'h00, 1, RWB, 0, 0);
        foreach (vec[i]) begin
            rst = vec[i].rst;
            if8.opcode_i = vec[i].opc;
            if8.mem_ready_i = vec[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(act8()), 32'(vec[i].exp));
            nxt();
        end
        // reset taken while a store waits on memory
        if8.opcode_i = 6'h2b;
        if8.mem_ready_i = 1'b1;
        repeat (6) nxt();
        if8.mem_ready_i = 1'b0;
        @(negedge clk); chk("sw_hold_mw", 32'(if8.mem_write), 1); nxt();
        @(negedge clk); chk("sw_hold_mw2", 32'(if8.mem_write), 1); nxt();
        rst = 1'b1;
        @(negedge clk); chk("rst_cyc_mw", 32'(if8.mem_write), 0); chk("rst_cyc_iord", 32'(if8.iord), 0); nxt();
        rst = 1'b0;
        if8.mem_ready_i = 1'b1;
        @(negedge clk);
        chk("post_rst_mw", 32'(if8.mem_write), 0);
        chk("post_rst_srcb", 32'(if8.alu_src_b), 1);
        chk("post_rst_irw", 32'(if8.ir_write), 0);
        chk("post_rst_pcw", 32'(if8.pc_write), 0);
        nxt();
        @(negedge clk); chk("post_rst_beat0", 32'(if8.ir_write), 4'b0001); nxt();
        if8.mem_ready_i = 1'b0;
        // 32-bit fetch, load with a 3-cycle memory stall
        rst = 1'b1;
        if32.opcode_i = 6'h23;
        if32.mem_ready_i = 1'b1;
        nxt();
        rst = 1'b0;
        nxt();
        @(negedge clk); chk("w32_irw", 32'(if32.ir_write), 1); chk("w32_pcw", 32'(if32.pc_write), 1); nxt();
        @(negedge clk); chk("w32_decode", 32'(if32.fetch_en), 1); nxt();
        @(negedge clk); chk("w32_memaddr", 32'(if32.alu_src_b), 2); nxt();
        if32.mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("w32_stall_iord%0d", i), 32'(if32.iord), 1);
            chk($sformatf("w32_stall_rw%0d", i), 32'(if32.reg_write), 0);
            nxt();
        end
        if32.mem_ready_i = 1'b1;
        @(negedge clk); chk("w32_rd_iord", 32'(if32.iord), 1); nxt();
        @(negedge clk);
        chk("w32_wb_m2r", 32'(if32.mem_to_reg), 1);
        chk("w32_wb_rw", 32'(if32.reg_write), 1);
        chk("w32_wb_iord", 32'(if32.iord), 0);
        nxt();
        @(negedge clk); chk("w32_back_rw", 32'(if32.reg_write), 0); chk("w32_back_irw", 32'(if32.ir_write), 1); nxt();
        if32.mem_ready_i = 1'b0;
        // 16-bit fetch stalled on beat 1
        rst = 1'b1;
        if16.mem_ready_i = 1'b1;
        nxt();
        rst = 1'b0;
        nxt();
        @(negedge clk); chk("w16_beat0", 32'(if16.ir_write), 2'b01); nxt();
        if16.mem_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("w16_stall_irw%0d", i), 32'(if16.ir_write), 0);
            chk($sformatf("w16_stall_pcw%0d", i), 32'(if16.pc_write), 0);
            nxt();
        end
        if16.mem_ready_i = 1'b1;
        @(negedge clk); chk("w16_beat1", 32'(if16.ir_write), 2'b10); chk("w16_beat1_pcw", 32'(if16.pc_write), 1); nxt();
        @(negedge clk); chk("w16_decode", 32'(if16.fetch_en), 1); nxt();
        if16.mem_ready_i = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
